b1to16_tdm_demuxer: RTL
=======================

// Module: b1to16_tdm_demuxer
// PURPOSE
// - Receive side of the 16-to-1 serial channel: a 1-bit TDM stream (slot 0 first) is distributed
//   into 16 slot registers and presented as a 16-bit parallel frame.
// - Sits after a b16to1 muxer driven by a slot counter, restoring x15_x0 at the far end.
// - Tracks frame alignment with a sync marker; flags misalignment with a sticky error.
// PARAMETERS
// - RESET_WORD  16'h0000  value loaded into z15_z0 on reset
// PORTS
// - clock    in   1   single system clock, all state updates on rising edge
// - reset    in   1   asynchronous, active-high reset
// - x0       in   1   serial data bit of the current slot
// - en       in   1   bit strobe: x0/sync sampled only on edges where en=1
// - sync     in   1   frame marker, high together with the slot-0 bit
// - clr_err  in   1   synchronous clear of err
// - z15_z0   out  16  last complete frame; bit i = slot i
// - valid    out  1   one-cycle pulse: z15_z0 just updated
// - b3_b0    out  4   index of next slot expected
// - err      out  1   sticky framing-error flag
// BEHAVIOUR
// - Reset (async, any time, incl. mid-frame): state=HUNT, b3_b0=0, shadow=0, z15_z0=RESET_WORD,
//   valid=0, err=0; partial frame discarded.
// - en=0: no state change; valid forced 0 (valid is high for at most one cycle).
// - HUNT, en=1, sync=1: shadow[0]<=x0, b3_b0<=1, ->RUN. HUNT, en=1, sync=0: ignored, stay HUNT.
// - RUN, en=1, b3_b0=k:
//   - k=0, sync=1: shadow[0]<=x0, b3_b0<=1 (normal frame start).
//   - k=0, sync=0: err<=1, ->HUNT, b3_b0 stays 0, bit dropped.
//   - 1<=k<=14, sync=0: shadow[k]<=x0, b3_b0<=k+1.
//   - k=15, sync=0: z15_z0<={x0,shadow[14:0]}, valid<=1, b3_b0<=0 (wrap), stay RUN.
//   - 1<=k<=15, sync=1: err<=1; resync: shadow[0]<=x0, b3_b0<=1; partial frame dropped, no valid.
// - Latency: z15_z0/valid change on the same edge that samples the slot-15 bit (visible next cycle).
// - z15_z0 holds its value between frames; shadow bits never leak to z15_z0 before slot 15.
// - err: set by either error case above; cleared by clr_err=1; simultaneous set and clear -> err=1.
// - Back-to-back frames with en=1 every cycle: one valid pulse every 16 cycles, no gap slot.
// - States: HUNT (1-bit encoding 0), RUN (1); b3_b0 is the slot counter, 4-bit, wraps 15->0.
// CONFIGURATION
// - Macro B16_DEMUX_ONEHOT_EN:
//   - defined: extra output port s15_s0 [15:0], registered one-hot strobe of the slot written on
//     that edge (bit k high one cycle when shadow[k] or, for k=15, z15_z0 is written);
//     all zeros on reset, when en=0, in HUNT-ignore, and on the k=0/sync=0 error.
//     Resync write of slot 0 sets s15_s0=16'h0001.
//   - undefined: port s15_s0 and its logic absent; all other behaviour identical.
// TESTING
// - Reset then frame 16'hA5C3 (slot 0 first, sync with slot 0, en=1 each cycle) -> after 16th edge
//   z15_z0=16'hA5C3, valid=1 for one cycle, b3_b0=0, err=0.
// - Two back-to-back frames 16'h0001, 16'h8000 -> valid pulses 16 cycles apart, z15_z0 sequence
//   0001 then 8000.
// - Frame 16'hFFFF with en toggling 1/0 -> 32 cycles to valid; z15_z0=16'hFFFF; no change on en=0 edges.
// - sync asserted at slot 7 mid-frame -> err=1, b3_b0=1, no valid; following 15 bits complete the
//   resynced frame with valid=1.
// - After one good frame, slot-0 bit without sync -> err=1, HUNT; bits ignored until next sync;
//   clr_err=1 -> err=0; clr_err together with new error -> err stays 1.
// - Assert reset at slot 9 -> z15_z0=RESET_WORD, b3_b0=0, valid=0 immediately (async);
//   with B16_DEMUX_ONEHOT_EN, slot 3 write -> s15_s0=16'h0008 one cycle.

Source files
------------

// File: rtl/b1to16_tdm_demuxer.sv
// b1to16_tdm_demuxer: 1-bit TDM stream (slot 0 first) to 16-bit parallel frame with sync tracking
// Ports: clock/reset (async, active-high); x0 serial bit; en bit strobe; sync frame marker on slot 0;
//   clr_err clears err; z15_z0 last complete frame; valid one-cycle update pulse;
//   b3_b0 next expected slot; err sticky framing error;
//   s15_s0 one-hot slot-write strobe (present only when B16_DEMUX_ONEHOT_EN is defined).
module b1to16_tdm_demuxer #(
  parameter logic [15:0] RESET_WORD = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        x0,
  input  logic        en,
  input  logic        sync,
  input  logic        clr_err,
`ifdef B16_DEMUX_ONEHOT_EN
  output logic [15:0] s15_s0,
`endif
  output logic [15:0] z15_z0,
  output logic        valid,
  output logic [3:0]  b3_b0,
  output logic        err
);
  typedef enum logic {HUNT = 1'b0, RUN = 1'b1} state_t;
  state_t      r_state;
  logic [14:0] r_shadow;
  logic [15:0] r_z;
  logic [15:0] r_strobe;
  logic [3:0]  r_cnt;
  logic        r_valid;
  logic        r_err;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state  <= HUNT;
      r_shadow <= '0;
      r_z      <= RESET_WORD;
      r_strobe <= '0;
      r_cnt    <= '0;
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_valid  <= 1'b0;
      r_strobe <= '0;
      // clear first so a same-cycle error below wins
      if (clr_err) r_err <= 1'b0;
      if (en) begin
        if (r_state == HUNT) begin
          if (sync) begin
            r_shadow[0] <= x0;
            r_cnt       <= 4'd1;
            r_state     <= RUN;
            r_strobe    <= 16'h0001;
          end
        end else if (sync) begin
          // normal start at slot 0, or resync (with error) anywhere else
          if (r_cnt != 4'd0) r_err <= 1'b1;
          r_shadow[0] <= x0;
          r_cnt       <= 4'd1;
          r_strobe    <= 16'h0001;
        end else if (r_cnt == 4'd0) begin
          r_err   <= 1'b1;
          r_state <= HUNT;
        end else if (r_cnt == 4'd15) begin
          r_z      <= {x0, r_shadow};
          r_valid  <= 1'b1;
          r_cnt    <= 4'd0;
          r_strobe <= 16'h8000;
        end else begin
          r_shadow[r_cnt] <= x0;
          r_cnt           <= r_cnt + 4'd1;
          r_strobe        <= 16'(1) << r_cnt;
        end
      end
    end
  end
  assign z15_z0 = r_z;
  assign valid  = r_valid;
  assign b3_b0  = r_cnt;
  assign err    = r_err;
`ifdef B16_DEMUX_ONEHOT_EN
  assign s15_s0 = r_strobe;
`else
  logic w_unused;
  assign w_unused = ^r_strobe;
`endif
endmodule
